// File: rtl/ct_mmu_dutlb_refill_pkg.sv
// Shared MMU definitions for the dutlb refill sequencer: field widths,
// jTLB page-size encodings and the refill FSM state type.
package ct_mmu_dutlb_refill_pkg;

  localparam int VPN_WIDTH = 27;
  localparam int PPN_WIDTH = 28;
  localparam int FLG_WIDTH = 14;

  localparam logic [2:0] PGS_4K = 3'b001;
  localparam logic [2:0] PGS_2M = 3'b010;
  localparam logic [2:0] PGS_1G = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_UPD     = 3'd3,
    ST_DISCARD = 3'd4
  } refill_state_e;

  // Any size other than the three one-hot encodings is treated as a fault.
  function automatic logic pgs_valid(input logic [2:0] pgs);
    logic ok;
    case (pgs)
      PGS_4K:  ok = 1'b1;
      PGS_2M:  ok = 1'b1;
      PGS_1G:  ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ct_mmu_dutlb_rr_ptr.sv
// Round-robin victim pointer for the regular dutlb entries, with a one-hot
// decode used directly as the entry write strobe.
module ct_mmu_dutlb_rr_ptr #(
  parameter int ENTRY_NUM = 16,
  localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 advance,
  output logic [PTR_W-1:0]     ptr,
  output logic [ENTRY_NUM-1:0] onehot
);
  import ct_mmu_dutlb_refill_pkg::*;

  logic [PTR_W-1:0] ptr_r;

  // Victim pointer: wraps explicitly so non-power-of-two entry counts work.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= (ptr_r == PTR_W'(ENTRY_NUM - 1)) ? '0 : ptr_r + PTR_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // One-hot decode of the current victim.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      onehot[i] = (ptr_r == PTR_W'(i));
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/ct_mmu_dutlb_refill.sv
// dutlb refill sequencer: arbitrates the two LSU miss ports, issues one jTLB
// request at a time and writes the result to a regular or the huge entry.
module ct_mmu_dutlb_refill #(
  parameter int ENTRY_NUM = 16,
  parameter int VPN_WIDTH = 27,
  parameter int PPN_WIDTH = 28,
  parameter int FLG_WIDTH = 14
) (
  input  logic                 utlb_clk,
  input  logic                 cpurst_b,
  input  logic                 utlb_miss0,
  input  logic                 utlb_miss1,
  input  logic [VPN_WIDTH-1:0] utlb_req_vpn0,
  input  logic [VPN_WIDTH-1:0] utlb_req_vpn1,
  input  logic                 regs_utlb_clr,
  input  logic                 tlboper_utlb_clr,
  output logic                 utlb_jtlb_req,
  output logic [VPN_WIDTH-1:0] utlb_jtlb_vpn,
  input  logic                 jtlb_utlb_grant,
  input  logic                 jtlb_utlb_resp_vld,
  input  logic                 jtlb_utlb_resp_hit,
  input  logic [2:0]           jtlb_utlb_pgs,
  input  logic [PPN_WIDTH-1:0] jtlb_utlb_ppn,
  input  logic [FLG_WIDTH-1:0] jtlb_utlb_flg,
  output logic [ENTRY_NUM-1:0] utlb_entry_upd,
  output logic                 utlb_huge_upd,
  output logic [VPN_WIDTH-1:0] utlb_upd_vpn,
  output logic [PPN_WIDTH-1:0] utlb_upd_ppn,
  output logic [FLG_WIDTH-1:0] utlb_upd_flg,
  output logic                 refill_busy,
  output logic [1:0]           refill_done,
  output logic [1:0]           refill_fault
);
  import ct_mmu_dutlb_refill_pkg::*;

  localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  refill_state_e          state_r;
  refill_state_e          state_nxt;
  logic                   clr_s;
  logic                   accept_s;
  logic                   resp_ok_s;
  logic                   resp_bad_s;
  logic                   upd_fire_s;
  logic                   advance_s;
  logic [VPN_WIDTH-1:0]   vpn_r;
  logic [1:0]             owner_r;
  logic                   req_r;
  logic                   huge_r;
  logic [1:0]             fault_r;
  logic [VPN_WIDTH-1:0]   upd_vpn_r;
  logic [PPN_WIDTH-1:0]   upd_ppn_r;
  logic [FLG_WIDTH-1:0]   upd_flg_r;
  logic [PTR_W-1:0]       victim_s;
  logic [ENTRY_NUM-1:0]   victim_onehot_s;

  assign clr_s      = regs_utlb_clr | tlboper_utlb_clr;
  assign accept_s   = (state_r == ST_IDLE) & (utlb_miss0 | utlb_miss1);
  assign resp_ok_s  = (state_r == ST_WAIT) & jtlb_utlb_resp_vld & ~clr_s
                    & jtlb_utlb_resp_hit & pgs_valid(jtlb_utlb_pgs);
  assign resp_bad_s = (state_r == ST_WAIT) & jtlb_utlb_resp_vld & ~clr_s
                    & ~(jtlb_utlb_resp_hit & pgs_valid(jtlb_utlb_pgs));
  assign upd_fire_s = (state_r == ST_UPD) & ~clr_s;
  assign advance_s  = upd_fire_s & ~huge_r;

  // State register.
  always_ff @(posedge utlb_clk) begin
    if (!cpurst_b) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic; a clear racing a grant or response decides between
  // dropping straight to IDLE and draining the response in DISCARD.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (utlb_miss0 | utlb_miss1) state_nxt = ST_REQ;
        else                         state_nxt = ST_IDLE;
      end
      ST_REQ: begin
        if (clr_s & jtlb_utlb_grant) state_nxt = ST_DISCARD;
        else if (clr_s)              state_nxt = ST_IDLE;
        else if (jtlb_utlb_grant)    state_nxt = ST_WAIT;
        else                         state_nxt = ST_REQ;
      end
      ST_WAIT: begin
        if (clr_s & jtlb_utlb_resp_vld) state_nxt = ST_IDLE;
        else if (clr_s)                 state_nxt = ST_DISCARD;
        else if (resp_ok_s)             state_nxt = ST_UPD;
        else if (resp_bad_s)            state_nxt = ST_IDLE;
        else                            state_nxt = ST_WAIT;
      end
      ST_UPD: state_nxt = ST_IDLE;
      ST_DISCARD: begin
        if (jtlb_utlb_resp_vld) state_nxt = ST_IDLE;
        else                    state_nxt = ST_DISCARD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture: port 0 wins; port 1 rides along only on an exact VPN match.
  always_ff @(posedge utlb_clk) begin
    if (!cpurst_b) begin
      vpn_r   <= '0;
      owner_r <= 2'b00;
    end else if (accept_s & utlb_miss0) begin
      vpn_r   <= utlb_req_vpn0;
      owner_r <= (utlb_miss1 && (utlb_req_vpn1 == utlb_req_vpn0)) ? 2'b11 : 2'b01;
    end else if (accept_s) begin
      vpn_r   <= utlb_req_vpn1;
      owner_r <= 2'b10;
    end else begin
      vpn_r   <= vpn_r;
      owner_r <= owner_r;
    end
  end

  // Registered request, fault pulse and update bus (loaded as the hit arrives).
  always_ff @(posedge utlb_clk) begin
    if (!cpurst_b) begin
      req_r     <= 1'b0;
      fault_r   <= 2'b00;
      huge_r    <= 1'b0;
      upd_vpn_r <= '0;
      upd_ppn_r <= '0;
      upd_flg_r <= '0;
    end else begin
      req_r   <= (state_nxt == ST_REQ);
      fault_r <= resp_bad_s ? owner_r : 2'b00;
      if (resp_ok_s) begin
        huge_r    <= (jtlb_utlb_pgs == PGS_1G);
        upd_vpn_r <= vpn_r;
        upd_ppn_r <= jtlb_utlb_ppn;
        upd_flg_r <= jtlb_utlb_flg;
      end else begin
        huge_r    <= huge_r;
        upd_vpn_r <= upd_vpn_r;
        upd_ppn_r <= upd_ppn_r;
        upd_flg_r <= upd_flg_r;
      end
    end
  end

  ct_mmu_dutlb_rr_ptr #(
    .ENTRY_NUM (ENTRY_NUM)
  ) u_rr_ptr (
    .clk     (utlb_clk),
    .rst_b   (cpurst_b),
    .advance (advance_s),
    .ptr     (victim_s),
    .onehot  (victim_onehot_s)
  );

  // Strobes stay combinational so a clear in UPD can still suppress them.
  assign utlb_entry_upd = advance_s ? victim_onehot_s : '0;
  assign utlb_huge_upd  = upd_fire_s & huge_r;
  assign refill_done    = upd_fire_s ? owner_r : 2'b00;
  assign refill_fault   = fault_r;
  assign refill_busy    = (state_r != ST_IDLE);
  assign utlb_jtlb_req  = req_r;
  assign utlb_jtlb_vpn  = vpn_r;
  assign utlb_upd_vpn   = upd_vpn_r;
  assign utlb_upd_ppn   = upd_ppn_r;
  assign utlb_upd_flg   = upd_flg_r;

endmodule

// File: tb/tb_ct_mmu_dutlb_refill.sv
// Self-checking bench for ct_mmu_dutlb_refill: table-driven refills scored
// through an expected-result queue, plus clear/reset corner sequences.
module tb_ct_mmu_dutlb_refill;

  logic        utlb_clk = 1'b0;
  logic        cpurst_b;
  logic        utlb_miss0, utlb_miss1;
  logic [26:0] utlb_req_vpn0, utlb_req_vpn1;
  logic        regs_utlb_clr, tlboper_utlb_clr;
  logic        utlb_jtlb_req;
  logic [26:0] utlb_jtlb_vpn;
  logic        jtlb_utlb_grant, jtlb_utlb_resp_vld, jtlb_utlb_resp_hit;
  logic [2:0]  jtlb_utlb_pgs;
  logic [27:0] jtlb_utlb_ppn;
  logic [13:0] jtlb_utlb_flg;
  logic [15:0] utlb_entry_upd;
  logic        utlb_huge_upd;
  logic [26:0] utlb_upd_vpn;
  logic [27:0] utlb_upd_ppn;
  logic [13:0] utlb_upd_flg;
  logic        refill_busy;
  logic [1:0]  refill_done, refill_fault;

  ct_mmu_dutlb_refill dut (
    .utlb_clk(utlb_clk), .cpurst_b(cpurst_b),
    .utlb_miss0(utlb_miss0), .utlb_miss1(utlb_miss1),
    .utlb_req_vpn0(utlb_req_vpn0), .utlb_req_vpn1(utlb_req_vpn1),
    .regs_utlb_clr(regs_utlb_clr), .tlboper_utlb_clr(tlboper_utlb_clr),
    .utlb_jtlb_req(utlb_jtlb_req), .utlb_jtlb_vpn(utlb_jtlb_vpn),
    .jtlb_utlb_grant(jtlb_utlb_grant), .jtlb_utlb_resp_vld(jtlb_utlb_resp_vld),
    .jtlb_utlb_resp_hit(jtlb_utlb_resp_hit), .jtlb_utlb_pgs(jtlb_utlb_pgs),
    .jtlb_utlb_ppn(jtlb_utlb_ppn), .jtlb_utlb_flg(jtlb_utlb_flg),
    .utlb_entry_upd(utlb_entry_upd), .utlb_huge_upd(utlb_huge_upd),
    .utlb_upd_vpn(utlb_upd_vpn), .utlb_upd_ppn(utlb_upd_ppn), .utlb_upd_flg(utlb_upd_flg),
    .refill_busy(refill_busy), .refill_done(refill_done), .refill_fault(refill_fault)
  );

  always #5 utlb_clk = ~utlb_clk;

  typedef struct {
    logic        m0, m1;
    logic [26:0] v0, v1;
    logic        hit;
    logic [2:0]  pgs;
    logic [27:0] ppn;
    logic [13:0] flg;
    logic [1:0]  exp_done, exp_fault;
    logic        exp_huge;
  } vec_t;

  typedef struct {
    logic [15:0] entry;
    logic        huge;
    logic [1:0]  done, fault;
    logic [26:0] vpn;
    logic [27:0] ppn;
    logic [13:0] flg;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vic     = 0;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: any strobe or pulse must match the head of the queue.
  always @(negedge utlb_clk) begin
    exp_t e;
    #2;
    if (cpurst_b === 1'b1 && (utlb_entry_upd !== 16'h0 || utlb_huge_upd !== 1'b0 ||
        refill_done !== 2'b00 || refill_fault !== 2'b00)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output", 64'({utlb_entry_upd, utlb_huge_upd, refill_done, refill_fault}), 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("entry_upd", 64'(utlb_entry_upd), 64'(e.entry));
        chk("huge_upd", 64'(utlb_huge_upd), 64'(e.huge));
        chk("refill_done", 64'(refill_done), 64'(e.done));
        chk("refill_fault", 64'(refill_fault), 64'(e.fault));
        if (e.done != 2'b00) begin
          chk("upd_vpn", 64'(utlb_upd_vpn), 64'(e.vpn));
          chk("upd_ppn", 64'(utlb_upd_ppn), 64'(e.ppn));
          chk("upd_flg", 64'(utlb_upd_flg), 64'(e.flg));
        end
      end
    end
  end

  task automatic idle_inputs();
    utlb_miss0 = 1'b0; utlb_miss1 = 1'b0;
    utlb_req_vpn0 = 27'h0; utlb_req_vpn1 = 27'h0;
    regs_utlb_clr = 1'b0; tlboper_utlb_clr = 1'b0;
    jtlb_utlb_grant = 1'b0; jtlb_utlb_resp_vld = 1'b0; jtlb_utlb_resp_hit = 1'b0;
    jtlb_utlb_pgs = 3'b000; jtlb_utlb_ppn = 28'h0; jtlb_utlb_flg = 14'h0;
  endtask

  // Launch a port-0 miss and walk it into WAIT (grant on the first REQ cycle).
  task automatic to_wait(input logic [26:0] vpn);
    @(negedge utlb_clk); utlb_miss0 = 1'b1; utlb_req_vpn0 = vpn;
    @(negedge utlb_clk); utlb_miss0 = 1'b0; jtlb_utlb_grant = 1'b1;
    @(negedge utlb_clk); jtlb_utlb_grant = 1'b0;
  endtask

  task automatic run_vec(input vec_t t, input string tag);
    exp_t e;
    e.vpn   = t.m0 ? t.v0 : t.v1;
    e.ppn   = t.ppn;
    e.flg   = t.flg;
    e.done  = t.exp_done;
    e.fault = t.exp_fault;
    e.huge  = t.exp_huge;
    e.entry = 16'h0;
    if (t.exp_done != 2'b00 && !t.exp_huge) begin
      e.entry = 16'h1 << vic;
      vic = (vic == 15) ? 0 : vic + 1;
    end
    sbq.push_back(e);
    @(negedge utlb_clk);
    utlb_miss0 = t.m0; utlb_miss1 = t.m1; utlb_req_vpn0 = t.v0; utlb_req_vpn1 = t.v1;
    @(negedge utlb_clk);
    utlb_miss0 = 1'b0; utlb_miss1 = 1'b0;
    #2;
    chk({tag, "_req"}, 64'(utlb_jtlb_req), 64'd1);
    chk({tag, "_req_vpn"}, 64'(utlb_jtlb_vpn), 64'(e.vpn));
    jtlb_utlb_grant = 1'b1;
    @(negedge utlb_clk);
    jtlb_utlb_grant = 1'b0;
    jtlb_utlb_resp_vld = 1'b1; jtlb_utlb_resp_hit = t.hit; jtlb_utlb_pgs = t.pgs;
    jtlb_utlb_ppn = t.ppn; jtlb_utlb_flg = t.flg;
    @(negedge utlb_clk);
    jtlb_utlb_resp_vld = 1'b0;
    @(negedge utlb_clk);
    #2;
    chk({tag, "_idle_busy"}, 64'(refill_busy), 64'd0);
    chk({tag, "_idle_req"}, 64'(utlb_jtlb_req), 64'd0);
  endtask

  initial begin
    vec_t lv;
    vecs[0] = '{1'b1, 1'b0, 27'h1234, 27'h0, 1'b1, 3'b001, 28'hABCDE, 14'h3F, 2'b01, 2'b00, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 27'h55, 27'h55, 1'b1, 3'b010, 28'h1111, 14'h01, 2'b11, 2'b00, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 27'h100, 27'h200, 1'b1, 3'b001, 28'h2222, 14'h02, 2'b01, 2'b00, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 27'h0, 27'h7FFFFFF, 1'b1, 3'b100, 28'hFFFFFFF, 14'h3FFF, 2'b10, 2'b00, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 27'h333, 27'h0, 1'b0, 3'b001, 28'h4444, 14'h04, 2'b00, 2'b01, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 27'h0, 27'h444, 1'b1, 3'b011, 28'h5555, 14'h05, 2'b00, 2'b10, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 27'h600, 27'h600, 1'b0, 3'b010, 28'h6666, 14'h06, 2'b00, 2'b11, 1'b0};

    idle_inputs();
    cpurst_b = 1'b0;
    repeat (3) @(negedge utlb_clk);
    #2;
    chk("rst_req", 64'(utlb_jtlb_req), 64'd0);
    chk("rst_vpn", 64'(utlb_jtlb_vpn), 64'd0);
    chk("rst_busy", 64'(refill_busy), 64'd0);
    chk("rst_strobes", 64'({utlb_entry_upd, utlb_huge_upd, refill_done, refill_fault}), 64'd0);
    chk("rst_upd_bus", 64'(utlb_upd_vpn) | 64'(utlb_upd_ppn) | 64'(utlb_upd_flg), 64'd0);
    cpurst_b = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Clear in WAIT, response three cycles later: drained silently.
    to_wait(27'h777);
    tlboper_utlb_clr = 1'b1;
    @(negedge utlb_clk); tlboper_utlb_clr = 1'b0; #2;
    chk("clrwait_discard_busy", 64'(refill_busy), 64'd1);
    @(negedge utlb_clk);
    @(negedge utlb_clk);
    jtlb_utlb_resp_vld = 1'b1; jtlb_utlb_resp_hit = 1'b1; jtlb_utlb_pgs = 3'b001;
    @(negedge utlb_clk); jtlb_utlb_resp_vld = 1'b0; #2;
    chk("clrwait_idle", 64'(refill_busy), 64'd0);

    // Clear in REQ without grant: straight back to IDLE.
    @(negedge utlb_clk); utlb_miss1 = 1'b1; utlb_req_vpn1 = 27'h888;
    @(negedge utlb_clk); utlb_miss1 = 1'b0; regs_utlb_clr = 1'b1;
    @(negedge utlb_clk); regs_utlb_clr = 1'b0; #2;
    chk("clrreq_busy", 64'(refill_busy), 64'd0);
    chk("clrreq_req", 64'(utlb_jtlb_req), 64'd0);

    // Clear together with grant: DISCARD until the response.
    @(negedge utlb_clk); utlb_miss0 = 1'b1; utlb_req_vpn0 = 27'h999;
    @(negedge utlb_clk); utlb_miss0 = 1'b0; regs_utlb_clr = 1'b1; jtlb_utlb_grant = 1'b1;
    @(negedge utlb_clk); regs_utlb_clr = 1'b0; jtlb_utlb_grant = 1'b0;
    @(negedge utlb_clk); #2;
    chk("clrgrant_discard_busy", 64'(refill_busy), 64'd1);
    chk("clrgrant_req", 64'(utlb_jtlb_req), 64'd0);
    jtlb_utlb_resp_vld = 1'b1; jtlb_utlb_resp_hit = 1'b1;
    @(negedge utlb_clk); jtlb_utlb_resp_vld = 1'b0; #2;
    chk("clrgrant_idle", 64'(refill_busy), 64'd0);

    // Clear in UPD: strobes suppressed, victim holds (checked by the next refill).
    to_wait(27'hAAA);
    jtlb_utlb_resp_vld = 1'b1; jtlb_utlb_resp_hit = 1'b1; jtlb_utlb_pgs = 3'b001;
    @(negedge utlb_clk); jtlb_utlb_resp_vld = 1'b0; tlboper_utlb_clr = 1'b1;
    @(negedge utlb_clk); tlboper_utlb_clr = 1'b0; #2;
    chk("clrupd_idle", 64'(refill_busy), 64'd0);
    lv = '{1'b1, 1'b0, 27'hBBB, 27'h0, 1'b1, 3'b001, 28'hBBBB, 14'h0B, 2'b01, 2'b00, 1'b0};
    run_vec(lv, "after_clrupd");

    // Miss arriving while busy is dropped: only one refill completes.
    lv = '{1'b0, 1'b1, 27'h0, 27'hCCC, 1'b1, 3'b010, 28'hCCCC, 14'h0C, 2'b10, 2'b00, 1'b0};
    fork
      run_vec(lv, "busy_drop");
      begin
        @(negedge utlb_clk); @(negedge utlb_clk);
        utlb_miss0 = 1'b1; utlb_req_vpn0 = 27'hDDD;
        @(negedge utlb_clk); utlb_miss0 = 1'b0;
      end
    join
    @(negedge utlb_clk); #2;
    chk("busy_drop_no_req", 64'(utlb_jtlb_req), 64'd0);

    // Reset mid-operation: back to IDLE, late response ignored, victim at 0.
    to_wait(27'hEEE);
    cpurst_b = 1'b0;
    @(negedge utlb_clk); cpurst_b = 1'b1; #2;
    vic = 0;
    chk("midrst_busy", 64'(refill_busy), 64'd0);
    chk("midrst_upd_ppn", 64'(utlb_upd_ppn), 64'd0);
    jtlb_utlb_resp_vld = 1'b1; jtlb_utlb_resp_hit = 1'b1; jtlb_utlb_pgs = 3'b001;
    @(negedge utlb_clk); jtlb_utlb_resp_vld = 1'b0;
    @(negedge utlb_clk); #2;
    chk("midrst_resp_ignored", 64'(refill_busy), 64'd0);

    // 17 back-to-back 4K refills: strobe walks bits 0..15 and wraps to bit 0.
    for (int i = 0; i < 17; i++) begin
      lv = '{1'b1, 1'b0, 27'(32'h1000 + i), 27'h0, 1'b1, 3'b001, 28'(32'h20000 + i), 14'(i), 2'b01, 2'b00, 1'b0};
      run_vec(lv, $sformatf("walk%0d", i));
    end

    repeat (2) @(negedge utlb_clk);
    #3;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
